mem_port_arbiter: RTL and testbench

- Shares the single-port 32x1024 block RAM between two requesters:
  - the NPC instruction-fetch path (read-only);
  - the data-memory path (loads/stores with byte strobes).
- Translates byte addresses into RAM word indices and rejects out-of-range or misaligned accesses.
- Enforces bounded-wait priority between the two requesters.
- Returns read data, or a write acknowledge, on the RAM's 1-cycle read latency. Sits between the NPC core and BLK_RAM_32x1024.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_addr_check.sv | 32 +++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the NPC memory-port arbiter.
//   BASE_ADDR_DEFAULT : byte address mapped to RAM word 0
//   rsp_type_e        : which requester owns a pipelined response
//   fault_cause_e     : access-fault causes, reserved for the trap logic
//   rsp_stage_t       : contents of the one-stage response register
package mem_pkg;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h8000_0000;

    typedef enum logic {
        RSP_IF = 1'b0,
        RSP_D  = 1'b1
    } rsp_type_e;

    typedef enum logic [1:0] {
        FAULT_NONE  = 2'd0,
        FAULT_RANGE = 2'd1,
        FAULT_ALIGN = 2'd2
    } fault_cause_e;

    typedef struct packed {
        logic      valid;
        rsp_type_e rsp_type;
        logic      is_write;
        logic      err;
    } rsp_stage_t;

endpackage

// File: rtl/mem_addr_check.sv
// Combinational byte-address to RAM-word translation with range/alignment check.
//   addr  : byte address from a requester
//   fault : address outside the RAM window or not word aligned
//   index : RAM word index (meaningful only when fault is low)
module mem_addr_check
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEFAULT,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic [31:0]           addr,
    output logic                  fault,
    output logic [DEPTH_LOG2-1:0] index
);

    // Window size in bytes; one extra bit so DEPTH_LOG2 = 30 still fits.
    localparam logic [32:0] SPAN = 33'(1) << (DEPTH_LOG2 + 2);

    logic [31:0] off;
    logic        range_fault;
    logic        align_fault;

    always_comb begin
        // Wraparound subtraction makes addresses below the base look huge.
        off         = addr - BASE_ADDR;
        range_fault = {1'b0, off} >= SPAN;
        align_fault = off[1:0] != 2'b00;
        fault       = range_fault | align_fault;
        index       = off[DEPTH_LOG2+1:2];
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port 32x1024 block RAM between NPC instruction fetch and data access.
//   clk, rst        : clock and asynchronous active-high reset
//   if_req_*        : fetch request (valid/addr) and combinational ready
//   if_rsp_*        : fetch response (valid/data/err), one cycle after grant
//   d_req_*         : data request (valid/addr/wstrb/wdata), wstrb == 0 is a read
//   d_rsp_*         : data response (valid/data/err); data is 0 for write acks
//   ram_*           : RAM word address, byte write enables, write data, read data
// Data wins by default; a pending fetch is forced through after MAX_D_STREAK
// consecutive data grants. MAX_D_STREAK must be at least 1.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = BASE_ADDR_DEFAULT,
    parameter int unsigned DEPTH_LOG2   = 10,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid,
    input  logic [31:0]           if_req_addr,
    output logic                  if_req_ready,
    output logic                  if_rsp_valid,
    output logic [31:0]           if_rsp_data,
    output logic                  if_rsp_err,
    input  logic                  d_req_valid,
    input  logic [31:0]           d_req_addr,
    input  logic [3:0]            d_req_wstrb,
    input  logic [31:0]           d_req_wdata,
    output logic                  d_req_ready,
    output logic                  d_rsp_valid,
    output logic [31:0]           d_rsp_data,
    output logic                  d_rsp_err,
    output logic [DEPTH_LOG2-1:0] ram_addr,
    output logic [3:0]            ram_wen,
    output logic [31:0]           ram_din,
    input  logic [31:0]           ram_dout
);

    localparam int unsigned         STREAK_W   = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic [DEPTH_LOG2-1:0] ram_addr_q, ram_addr_d;
    rsp_stage_t            rsp_q, rsp_d;

    logic                  if_grant, d_grant;
    logic                  if_fault, d_fault;
    logic                  d_is_write;
    logic [DEPTH_LOG2-1:0] if_index, d_index;
    logic [31:0]           rd_data;

    mem_addr_check #(
        .BASE_ADDR  (BASE_ADDR),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_if_check (
        .addr  (if_req_addr),
        .fault (if_fault),
        .index (if_index)
    );

    mem_addr_check #(
        .BASE_ADDR  (BASE_ADDR),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_d_check (
        .addr  (d_req_addr),
        .fault (d_fault),
        .index (d_index)
    );

    // Grant and next-state logic.
    always_comb begin
        d_grant    = d_req_valid && !(if_req_valid && (streak_q == STREAK_MAX));
        if_grant   = if_req_valid && !d_grant;
        d_is_write = d_req_wstrb != 4'b0000;

        // Streak only measures data grants that made a fetch wait.
        if (!if_req_valid || if_grant) begin
            streak_d = '0;
        end else if (d_grant && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end else begin
            streak_d = streak_q;
        end

        // Faulting grants park the address at 0; idle cycles hold it.
        if (d_grant) begin
            ram_addr_d = d_fault ? '0 : d_index;
        end else if (if_grant) begin
            ram_addr_d = if_fault ? '0 : if_index;
        end else begin
            ram_addr_d = ram_addr_q;
        end

        rsp_d.valid    = d_grant || if_grant;
        rsp_d.rsp_type = d_grant ? RSP_D : RSP_IF;
        rsp_d.is_write = d_grant && d_is_write;
        rsp_d.err      = d_grant ? d_fault : (if_grant && if_fault);
    end

    // Request-side outputs are forced low while reset is held.
    always_comb begin
        if_req_ready = !rst && if_grant;
        d_req_ready  = !rst && d_grant;
        ram_addr     = rst ? '0 : ram_addr_d;
        ram_wen      = (!rst && d_grant && !d_fault) ? d_req_wstrb : 4'b0000;
        ram_din      = rst ? '0 : d_req_wdata;
    end

    // Response-side outputs follow the registered stage (cleared by reset).
    always_comb begin
        rd_data      = (rsp_q.valid && !rsp_q.is_write && !rsp_q.err) ? ram_dout : '0;
        if_rsp_valid = rsp_q.valid && (rsp_q.rsp_type == RSP_IF);
        d_rsp_valid  = rsp_q.valid && (rsp_q.rsp_type == RSP_D);
        if_rsp_data  = if_rsp_valid ? rd_data : '0;
        d_rsp_data   = d_rsp_valid ? rd_data : '0;
        if_rsp_err   = if_rsp_valid && rsp_q.err;
        d_rsp_err    = d_rsp_valid && rsp_q.err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q   <= '0;
            ram_addr_q <= '0;
            rsp_q      <= '0;
        end else begin
            streak_q   <= streak_d;
            ram_addr_q <= ram_addr_d;
            rsp_q      <= rsp_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a write-first RAM model and a
// response scoreboard fed from an independent shadow memory.
module tb_mem_port_arbiter;

    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        if_rsp_err;
    logic        d_req_valid;
    logic [31:0] d_req_addr;
    logic [3:0]  d_req_wstrb;
    logic [31:0] d_req_wdata;
    logic        d_req_ready;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        d_rsp_err;
    logic [9:0]  ram_addr;
    logic [3:0]  ram_wen;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    logic [31:0] ram    [0:1023];
    logic [31:0] shadow [0:1023];
    logic [31:0] ram_merged;

    exp_t if_q[$];
    exp_t d_q[$];

    int n_cmp;
    int n_mis;

    mem_port_arbiter #(
        .BASE_ADDR    (BASE),
        .DEPTH_LOG2   (10),
        .MAX_D_STREAK (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_addr  (if_req_addr),
        .if_req_ready (if_req_ready),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .if_rsp_err   (if_rsp_err),
        .d_req_valid  (d_req_valid),
        .d_req_addr   (d_req_addr),
        .d_req_wstrb  (d_req_wstrb),
        .d_req_wdata  (d_req_wdata),
        .d_req_ready  (d_req_ready),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_data   (d_rsp_data),
        .d_rsp_err    (d_rsp_err),
        .ram_addr     (ram_addr),
        .ram_wen      (ram_wen),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first single-port RAM, 1-cycle read latency.
    always_comb begin
        ram_merged = ram[ram_addr];
        for (int b = 0; b < 4; b++) begin
            if (ram_wen[b]) ram_merged[8*b +: 8] = ram_din[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (|ram_wen) ram[ram_addr] <= ram_merged;
        ram_dout <= ram_merged;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic addr_fault(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off >= 32'h0000_1000) || (off[1:0] != 2'b00);
    endfunction

    function automatic logic [9:0] addr_index(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off[11:2];
    endfunction

    // Monitor: compare responses first, then record this cycle's grants.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic        f;
        logic [9:0]  idx;
        logic [31:0] w;
        if (rst) begin
            if_q.delete();
            d_q.delete();
            chk("rst_ctl", 64'({if_req_ready, if_rsp_valid, if_rsp_err,
                                d_req_ready, d_rsp_valid, d_rsp_err}), 64'd0);
            chk("rst_ram", 64'({ram_wen, ram_addr}), 64'd0);
            chk("rst_data", {if_rsp_data, d_rsp_data}, 64'd0);
            chk("rst_din", 64'(ram_din), 64'd0);
        end else begin
            if (if_rsp_valid) begin
                if (if_q.size() == 0) begin
                    chk("if_rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = if_q.pop_front();
                    chk("if_rsp_data", 64'(if_rsp_data), 64'(e.data));
                    chk("if_rsp_err", 64'(if_rsp_err), 64'(e.err));
                end
            end else if (if_q.size() != 0) begin
                void'(if_q.pop_front());
                chk("if_rsp_missing", 64'd0, 64'd1);
            end
            if (d_rsp_valid) begin
                if (d_q.size() == 0) begin
                    chk("d_rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = d_q.pop_front();
                    chk("d_rsp_data", 64'(d_rsp_data), 64'(e.data));
                    chk("d_rsp_err", 64'(d_rsp_err), 64'(e.err));
                end
            end else if (d_q.size() != 0) begin
                void'(d_q.pop_front());
                chk("d_rsp_missing", 64'd0, 64'd1);
            end

            if (if_req_ready && d_req_ready) chk("ready_exclusive", 64'd1, 64'd0);

            if (if_req_valid && if_req_ready) begin
                f   = addr_fault(if_req_addr);
                idx = addr_index(if_req_addr);
                e.err  = f;
                e.data = f ? 32'h0 : shadow[idx];
                if_q.push_back(e);
                chk("if_wen", 64'(ram_wen), 64'd0);
                if (!f) chk("if_ram_addr", 64'(ram_addr), 64'(idx));
            end
            if (d_req_valid && d_req_ready) begin
                f   = addr_fault(d_req_addr);
                idx = addr_index(d_req_addr);
                e.err = f;
                if (d_req_wstrb != 4'b0000) begin
                    e.data = 32'h0;
                    chk("d_wen", 64'(ram_wen), f ? 64'd0 : 64'(d_req_wstrb));
                    if (!f) begin
                        w = shadow[idx];
                        for (int b = 0; b < 4; b++) begin
                            if (d_req_wstrb[b]) w[8*b +: 8] = d_req_wdata[8*b +: 8];
                        end
                        shadow[idx] = w;
                    end
                end else begin
                    e.data = f ? 32'h0 : shadow[idx];
                    chk("d_wen", 64'(ram_wen), 64'd0);
                end
                if (!f) chk("d_ram_addr", 64'(ram_addr), 64'(idx));
                d_q.push_back(e);
            end
        end
    end

    task automatic drive(input logic ifv, input logic [31:0] ifa, input logic dv,
                         input logic [31:0] da, input logic [3:0] ws, input logic [31:0] wd);
        @(posedge clk);
        #1;
        if_req_valid = ifv;
        if_req_addr  = ifa;
        d_req_valid  = dv;
        d_req_addr   = da;
        d_req_wstrb  = ws;
        d_req_wdata  = wd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    // Both requesters continuously valid; each advances its address on acceptance.
    task automatic both_valid(input string tag, input int cycles, input int d_word0,
                              input int f_word0, output int max_wait);
        int dn, fn, wait_cnt;
        dn       = 0;
        fn       = 0;
        wait_cnt = 0;
        max_wait = 0;
        for (int k = 0; k < cycles; k++) begin
            drive(1'b1, BASE + 32'(4 * (f_word0 + fn)), 1'b1, BASE + 32'(4 * (d_word0 + dn)),
                  4'h0, 32'h0);
            @(negedge clk);
            chk({tag, "_if_rdy"}, 64'(if_req_ready), 64'((k % 5) == 4));
            chk({tag, "_d_rdy"}, 64'(d_req_ready), 64'((k % 5) != 4));
            if (if_req_ready) begin
                fn++;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
                if (wait_cnt > max_wait) max_wait = wait_cnt;
            end
            if (d_req_ready) dn++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mw;
        n_cmp        = 0;
        n_mis        = 0;
        rst          = 1'b1;
        if_req_valid = 1'b0;
        if_req_addr  = 32'h0;
        d_req_valid  = 1'b0;
        d_req_addr   = 32'h0;
        d_req_wstrb  = 4'h0;
        d_req_wdata  = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            ram[i]    = (32'(i) * 32'h0101_0101) ^ 32'hDEAD_0000;
            shadow[i] = ram[i];
        end
        ram[0] = 32'h0000_0413;  shadow[0] = 32'h0000_0413;
        ram[1] = 32'h0010_0073;  shadow[1] = 32'h0010_0073;
        ram[4] = 32'h1122_3344;  shadow[4] = 32'h1122_3344;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Fetch-only stream.
        drive(1'b1, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("fo_rdy0", 64'(if_req_ready), 64'd1);
        drive(1'b1, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("fo_rdy1", 64'(if_req_ready), 64'd1);
        idle(2);

        // Partial store followed by load of the same word.
        drive(1'b0, 32'h0, 1'b1, 32'h8000_0010, 4'b0011, 32'hAAAA_BBBB);
        @(negedge clk);
        chk("st_rdy", 64'(d_req_ready), 64'd1);
        drive(1'b0, 32'h0, 1'b1, 32'h8000_0010, 4'b0000, 32'h0);
        idle(1);
        chk("st_shadow", 64'(shadow[4]), 64'h1122_BBBB);
        idle(1);

        // Faulting accesses.
        drive(1'b0, 32'h0, 1'b1, 32'h8000_1000, 4'b0000, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 32'h8000_0002, 4'b1111, 32'hFFFF_FFFF);
        drive(1'b1, 32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, 32'h0);
        idle(2);
        chk("fault_no_side_effect", 64'(ram[0]), 64'h0000_0413);

        // Starvation bound: D,D,D,D,F repeating.
        both_valid("starve", 15, 32, 64, mw);
        chk("starve_max_wait", 64'(mw <= 4), 64'd1);
        idle(2);

        // Fetch alone first, then contention; streak must start from 0.
        drive(1'b1, BASE + 32'h100, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("ce_if_first", 64'(if_req_ready), 64'd1);
        both_valid("ce", 5, 96, 80, mw);
        idle(2);

        // Reset with a data read granted the cycle before; fetch held valid in reset.
        drive(1'b0, 32'h0, 1'b1, 32'h8000_0020, 4'h0, 32'h0);
        @(negedge clk);
        #1;
        rst          = 1'b1;
        d_req_valid  = 1'b0;
        if_req_valid = 1'b1;
        if_req_addr  = BASE;
        repeat (2) @(negedge clk);
        #1 if_req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_d_rsp", 64'(d_rsp_valid), 64'd0);
        end

        // Requester reissues after reset.
        drive(1'b0, 32'h0, 1'b1, 32'h8000_0020, 4'h0, 32'h0);
        idle(3);
        chk("sb_drain", 64'(if_q.size() + d_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
